// File: rtl/game_pkg.sv
// Shared definitions for the switch-target game: state encoding, LFSR taps, timer widths.
package game_pkg;

    localparam int TIME_W   = 6;
    localparam int MS_W     = 10;
    localparam int MS_PER_S = 1000;

    // Fibonacci taps 16,14,13,11 expressed as a mask over lfsr[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
    localparam logic [1:0] ST_SPAWN_ENC  = 2'd1;
    localparam logic [1:0] ST_ACTIVE_ENC = 2'd2;
    localparam logic [1:0] ST_OVER_ENC   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_SPAWN  = ST_SPAWN_ENC,
        ST_ACTIVE = ST_ACTIVE_ENC,
        ST_OVER   = ST_OVER_ENC
    } state_t;

endpackage

// File: rtl/target_scheduler_if.sv
// Start/hit inputs and target/status outputs between the scheduler and its neighbours.
interface target_scheduler_if
    import game_pkg::*;
#(
    parameter int N_SW = 18
) ();
    logic              start;
    logic              target_hit;
    logic [N_SW-1:0]   curr_target;
    logic              game_over;
    logic [TIME_W-1:0] time_left;
    logic              new_target;
    logic              busy;

    modport master (
        output start, target_hit,
        input  curr_target, game_over, time_left, new_target, busy
    );

    modport slave (
        input  start, target_hit,
        output curr_target, game_over, time_left, new_target, busy
    );
endinterface

// File: rtl/target_scheduler_tick_gen.sv
// Millisecond prescaler: pulses o_ms_tick on the last cycle of each CLK_HZ/1000 period while enabled.
module tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_ms_tick
);
    localparam int DIV = CLK_HZ / 1000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign o_ms_tick = i_en && (r_cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_ms_tick ? '0 : r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/target_scheduler.sv
// Round sequencer: picks lit targets from an LFSR, times target lifetime and round length.
// state  | meaning
// IDLE   | after reset, waiting for start, scoring frozen
// SPAWN  | one cycle, choose and light the next target
// ACTIVE | target lit, waiting for hit, life timeout or round expiry
// OVER   | round finished, scoring frozen, start replays
module target_scheduler
    import game_pkg::*;
#(
    parameter int          N_SW         = 18,
    parameter int          CLK_HZ       = 50_000_000,
    parameter int          GAME_S       = 30,
    parameter int          LIFE_MS_INIT = 2000,
    parameter int          LIFE_MS_MIN  = 500,
    parameter int          LIFE_STEP_MS = 100,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst_n,
    target_scheduler_if.slave   bus
);
    localparam int LIFE_W = $clog2(LIFE_MS_INIT + 1);
    localparam int IDX_W  = (N_SW > 1) ? $clog2(N_SW) : 1;

    state_t              r_state, w_nxt_state;
    logic [15:0]         r_lfsr;
    logic [LIFE_W-1:0]   r_life, w_nxt_life;
    logic [LIFE_W-1:0]   r_life_cnt, w_nxt_life_cnt;
    logic [MS_W-1:0]     r_ms_cnt, w_nxt_ms_cnt;
    logic [TIME_W-1:0]   r_time_left, w_nxt_time_left;
    logic [N_SW-1:0]     r_curr_target, w_nxt_target;
    logic [IDX_W-1:0]    r_prev_idx, w_nxt_prev_idx;
    logic                r_new_target, w_nxt_new_target;
    logic                r_game_over, r_busy, w_nxt_frozen;
    logic                w_ms_tick, w_tick_en, w_tick_clr;
    logic                w_ms_wrap, w_expire;
    logic [IDX_W-1:0]    w_idx_raw, w_idx;

    assign w_tick_en = (r_state == ST_SPAWN) || (r_state == ST_ACTIVE);

    tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (w_tick_en),
        .i_clr     (w_tick_clr),
        .o_ms_tick (w_ms_tick)
    );

    // Never repeat the previous target: bump to the neighbour on a collision
    assign w_idx_raw = IDX_W'(r_lfsr % 16'(N_SW));
    assign w_idx     = (w_idx_raw != r_prev_idx) ? w_idx_raw :
                       (w_idx_raw == IDX_W'(N_SW - 1)) ? '0 : w_idx_raw + 1'b1;

    assign w_ms_wrap = w_ms_tick && (r_ms_cnt == MS_W'(MS_PER_S - 1));
    assign w_expire  = w_ms_wrap && (r_time_left == TIME_W'(1));

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_life       = r_life;
        w_nxt_life_cnt   = r_life_cnt;
        w_nxt_ms_cnt     = r_ms_cnt;
        w_nxt_time_left  = r_time_left;
        w_nxt_target     = r_curr_target;
        w_nxt_prev_idx   = r_prev_idx;
        w_nxt_new_target = 1'b0;
        w_tick_clr       = 1'b0;

        // Round time keeps running through SPAWN so hits do not stretch the round
        if (w_tick_en && w_ms_tick) begin
            w_nxt_ms_cnt = w_ms_wrap ? '0 : r_ms_cnt + 1'b1;
            if (w_ms_wrap) w_nxt_time_left = r_time_left - 1'b1;
        end

        case (r_state)
            ST_IDLE, ST_OVER: begin
                w_nxt_target = '0;
                if (bus.start) begin
                    w_nxt_state     = ST_SPAWN;
                    w_nxt_time_left = TIME_W'(GAME_S);
                    w_nxt_life      = LIFE_W'(LIFE_MS_INIT);
                    w_nxt_ms_cnt    = '0;
                    w_tick_clr      = 1'b1;
                end
            end
            ST_SPAWN: begin
                if (w_expire) begin
                    w_nxt_state  = ST_OVER;
                    w_nxt_target = '0;
                end else begin
                    w_nxt_state      = ST_ACTIVE;
                    w_nxt_target     = N_SW'(1) << w_idx;
                    w_nxt_prev_idx   = w_idx;
                    w_nxt_new_target = 1'b1;
                    w_nxt_life_cnt   = r_life;
                end
            end
            ST_ACTIVE: begin
                if (w_expire) begin
                    w_nxt_state  = ST_OVER;
                    w_nxt_target = '0;
                end else if (bus.target_hit) begin
                    w_nxt_state  = ST_SPAWN;
                    w_nxt_target = '0;
                    if (int'(r_life) >= LIFE_MS_MIN + LIFE_STEP_MS)
                        w_nxt_life = r_life - LIFE_W'(LIFE_STEP_MS);
                    else
                        w_nxt_life = LIFE_W'(LIFE_MS_MIN);
                end else if (w_ms_tick) begin
                    w_nxt_life_cnt = r_life_cnt - 1'b1;
                    if (r_life_cnt <= LIFE_W'(1)) begin
                        w_nxt_state  = ST_SPAWN;
                        w_nxt_target = '0;
                    end
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase

        w_nxt_frozen = (w_nxt_state == ST_IDLE) || (w_nxt_state == ST_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_lfsr        <= LFSR_SEED;
            r_life        <= LIFE_W'(LIFE_MS_INIT);
            r_life_cnt    <= '0;
            r_ms_cnt      <= '0;
            r_time_left   <= TIME_W'(GAME_S);
            r_curr_target <= '0;
            r_prev_idx    <= '0;
            r_new_target  <= 1'b0;
            r_game_over   <= 1'b1;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_lfsr        <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
            r_life        <= w_nxt_life;
            r_life_cnt    <= w_nxt_life_cnt;
            r_ms_cnt      <= w_nxt_ms_cnt;
            r_time_left   <= w_nxt_time_left;
            r_curr_target <= w_nxt_target;
            r_prev_idx    <= w_nxt_prev_idx;
            r_new_target  <= w_nxt_new_target;
            r_game_over   <= w_nxt_frozen;
            r_busy        <= !w_nxt_frozen;
        end
    end

    assign bus.curr_target = r_curr_target;
    assign bus.game_over   = r_game_over;
    assign bus.time_left   = r_time_left;
    assign bus.new_target  = r_new_target;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_target_scheduler.sv
// Directed bench for target_scheduler with a 10-cycle millisecond, 2 s rounds and 5/3/1 ms lifetimes.
module tb_target_scheduler;
    import game_pkg::*;

    localparam int N_SW = 18;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    target_scheduler_if #(.N_SW(N_SW)) bus ();

    target_scheduler #(
        .N_SW         (N_SW),
        .CLK_HZ       (10_000),
        .GAME_S       (2),
        .LIFE_MS_INIT (5),
        .LIFE_MS_MIN  (3),
        .LIFE_STEP_MS (1),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int k        = 0;      // cycles since the most recent SPAWN entry from IDLE/OVER
    int prev_idx = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic run_to(input int t);
        while (k < t) step();
    endtask

    function automatic int onehot_idx(input logic [N_SW-1:0] v);
        int idx = -1;
        int cnt = 0;
        for (int i = 0; i < N_SW; i++) begin
            if (v[i]) begin
                idx = i;
                cnt++;
            end
        end
        return (cnt == 1) ? idx : -1;
    endfunction

    task automatic check_spawn(input string tag);
        int idx;
        idx = onehot_idx(bus.curr_target);
        chk({tag, "_new_target"}, bus.new_target, 1);
        chk({tag, "_onehot"}, idx >= 0, 1);
        chk({tag, "_idx_differs"}, idx != prev_idx, 1);
        prev_idx = idx;
    endtask

    // Target alive on kz-1, dark on kz (SPAWN), next target on kz+1
    task automatic check_gap(input string tag, input int kz);
        run_to(kz - 1);
        chk({tag, "_alive"}, bus.curr_target != '0, 1);
        step();
        chk({tag, "_dark"}, bus.curr_target, 0);
        chk({tag, "_dark_pulse"}, bus.new_target, 0);
        step();
        check_spawn(tag);
    endtask

    task automatic hit_at(input string tag, input int kh);
        run_to(kh);
        bus.target_hit = 1'b1;
        step();
        bus.target_hit = 1'b0;
        chk({tag, "_dark"}, bus.curr_target, 0);
        chk({tag, "_dark_pulse"}, bus.new_target, 0);
        step();
        check_spawn(tag);
    endtask

    task automatic pulse_start();
        k = -1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;
        bus.start      = 1'b0;
        bus.target_hit = 1'b0;

        // 1: reset values, then idle with a stray hit
        #12;
        chk("rst_game_over", bus.game_over, 1);
        chk("rst_target", bus.curr_target, 0);
        chk("rst_time_left", bus.time_left, 2);
        chk("rst_busy", bus.busy, 0);
        step();
        rst_n = 1'b1;
        bus.target_hit = 1'b1;
        step();
        bus.target_hit = 1'b0;
        repeat (100) step();
        chk("idle_game_over", bus.game_over, 1);
        chk("idle_target", bus.curr_target, 0);
        chk("idle_time_left", bus.time_left, 2);
        chk("idle_busy", bus.busy, 0);
        chk("idle_new_target", bus.new_target, 0);

        // 2: start latency
        pulse_start();
        chk("start_game_over", bus.game_over, 0);
        chk("start_busy", bus.busy, 1);
        chk("start_target_dark", bus.curr_target, 0);
        step();
        check_spawn("first");
        step();
        chk("first_pulse_len", bus.new_target, 0);

        // 3: unhit targets time out after 5 ms
        check_gap("miss1", 50);
        check_gap("miss2", 100);

        // 4: hits shrink lifetime 4, 3, 3 ms
        hit_at("hit1", 109);
        check_gap("life4", 150);
        hit_at("hit2", 159);
        check_gap("life3a", 190);
        hit_at("hit3", 199);
        check_gap("life3b", 230);

        // start while ACTIVE is ignored
        run_to(240);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("busy_start_game_over", bus.game_over, 0);
        chk("busy_start_target", bus.curr_target != '0, 1);
        chk("busy_start_pulse", bus.new_target, 0);
        check_gap("after_start", 260);

        // 5: round timing and expiry with a coincident hit
        run_to(9999);
        chk("time_2", bus.time_left, 2);
        step();
        chk("time_1", bus.time_left, 1);
        run_to(19999);
        chk("pre_expire_time", bus.time_left, 1);
        chk("pre_expire_target", bus.curr_target != '0, 1);
        bus.target_hit = 1'b1;
        step();
        bus.target_hit = 1'b0;
        chk("expire_game_over", bus.game_over, 1);
        chk("expire_target", bus.curr_target, 0);
        chk("expire_time", bus.time_left, 0);
        chk("expire_busy", bus.busy, 0);
        chk("expire_pulse", bus.new_target, 0);
        bad = 1'b0;
        repeat (30) begin
            step();
            if (bus.new_target || bus.curr_target != '0 || !bus.game_over) bad = 1'b1;
        end
        chk("over_quiet", bad, 0);

        pulse_start();
        chk("restart_game_over", bus.game_over, 0);
        chk("restart_time", bus.time_left, 2);
        step();
        check_spawn("restart");
        check_gap("restart_life5", 50);

        // 6: asynchronous reset mid-ACTIVE
        run_to(60);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_game_over", bus.game_over, 1);
        chk("arst_target", bus.curr_target, 0);
        chk("arst_time", bus.time_left, 2);
        chk("arst_busy", bus.busy, 0);
        chk("arst_pulse", bus.new_target, 0);
        step();
        rst_n = 1'b1;
        prev_idx = -1;
        step();
        pulse_start();
        chk("post_rst_game_over", bus.game_over, 0);
        step();
        check_spawn("post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
